registrador_piso_serial: RTL and testbench

//   Parallel-in/serial-out transmit register. It is the unloading end of the

---
 rtl/registrador_piso_serial.sv | 71 +++++++
 tb/tb_registrador_piso_serial.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/registrador_piso_serial.sv
// rtl/registrador_piso_serial.sv - parallel-in/serial-out transmit register
// Captures a word on ld and shifts it out one bit per enabled cycle, falling-edge clocked.

module registrador_piso_serial #(
   parameter int WIDTH     = 4,
   parameter bit LSB_FIRST = 1'b1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             ld,
   input  logic [WIDTH-1:0] d,
   input  logic             en,
   output logic             so,
   output logic             so_valid,
   output logic             busy,
   output logic             done
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      SHIFT = 2'b01,
      DONE  = 2'b10
   } state_t;

   state_t             state;
   logic [WIDTH-1:0]   sreg;
   logic [CNT_W-1:0]   cnt;
   logic               out_bit;

   always_ff @(negedge clock) begin
      if (reset) begin
         state <= IDLE;
         sreg  <= '0;
         cnt   <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (ld) begin
                  sreg  <= d;
                  cnt   <= '0;
                  state <= SHIFT;
               end else begin
                  state <= IDLE;
               end
            end
            SHIFT: begin
               if (en) begin
                  if (cnt == LAST) begin
                     state <= DONE;
                  end else begin
                     // move the next bit toward whichever end drives so
                     sreg <= LSB_FIRST ? (sreg >> 1) : (sreg << 1);
                     cnt  <= cnt + 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign out_bit  = LSB_FIRST ? sreg[0] : sreg[WIDTH-1];
   assign so_valid = (state == SHIFT);
   assign busy     = (state == SHIFT);
   assign done     = (state == DONE);
   assign so       = (state == SHIFT) ? out_bit : 1'b0;

endmodule

// File: tb/tb_registrador_piso_serial.sv
// tb/tb_registrador_piso_serial.sv - bench for registrador_piso_serial
// Drives LSB-first and MSB-first instances together and checks them against a word/index model.

module tb_registrador_piso_serial;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       ld    = 1'b0;
   logic [3:0] d     = 4'h0;
   logic       en    = 1'b1;

   logic so_l, so_valid_l, busy_l, done_l;
   logic so_m, so_valid_m, busy_m, done_m;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clock = ~clock;

   registrador_piso_serial #(.WIDTH(4), .LSB_FIRST(1'b1)) u_lsb (
      .clock(clock), .reset(reset), .ld(ld), .d(d), .en(en),
      .so(so_l), .so_valid(so_valid_l), .busy(busy_l), .done(done_l)
   );

   registrador_piso_serial #(.WIDTH(4), .LSB_FIRST(1'b0)) u_msb (
      .clock(clock), .reset(reset), .ld(ld), .d(d), .en(en),
      .so(so_m), .so_valid(so_valid_m), .busy(busy_m), .done(done_m)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: a word being sent and how many bits of it have gone out.
   bit       m_active = 1'b0;
   bit       m_done   = 1'b0;
   int       m_idx    = 0;
   bit [3:0] m_word   = 4'h0;

   always @(negedge clock) begin
      if (reset) begin
         m_active = 1'b0;
         m_done   = 1'b0;
         m_idx    = 0;
      end else if (m_active) begin
         if (en) begin
            if (m_idx == 3) begin
               m_active = 1'b0;
               m_done   = 1'b1;
            end else begin
               m_idx++;
            end
         end
      end else begin
         m_done = 1'b0;
         if (ld) begin
            m_word   = d;
            m_idx    = 0;
            m_active = 1'b1;
         end
      end
   end

   bit          chk_en = 1'b0;
   logic [31:0] rec_l  = '0;
   logic [31:0] rec_m  = '0;
   int          rec_n  = 0;
   int          n_done = 0;

   always @(posedge clock) begin
      if (chk_en) begin
         check("so_lsb",   so_l,       m_active ? m_word[m_idx] : 1'b0);
         check("so_msb",   so_m,       m_active ? m_word[3 - m_idx] : 1'b0);
         check("valid_l",  so_valid_l, m_active);
         check("valid_m",  so_valid_m, m_active);
         check("busy_l",   busy_l,     m_active);
         check("busy_m",   busy_m,     m_active);
         check("done_l",   done_l,     m_done);
         check("done_m",   done_m,     m_done);
         if (so_valid_l) begin
            rec_l = {rec_l[30:0], so_l};
            rec_m = {rec_m[30:0], so_m};
            rec_n++;
         end
         if (done_l) n_done++;
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic clear_rec();
      rec_l  = '0;
      rec_m  = '0;
      rec_n  = 0;
      n_done = 0;
   endtask

   initial begin
      // reset held with a pending load; nothing must be taken
      reset = 1'b1; ld = 1'b1; d = 4'hF; en = 1'b1;
      tick();
      chk_en = 1'b1;
      tick();
      check("rst_so",    so_l,       1'b0);
      check("rst_valid", so_valid_l, 1'b0);
      check("rst_busy",  busy_l,     1'b0);
      check("rst_done",  done_l,     1'b0);
      reset = 1'b0; ld = 1'b0;
      tick();
      check("rst_noload", rec_n, 0);

      // plain word, both bit orders
      clear_rec();
      ld = 1'b1; d = 4'b1011;
      tick();
      ld = 1'b0;
      repeat (6) tick();
      check("t2_bits_lsb", rec_l, 32'b1101);
      check("t3_bits_msb", rec_m, 32'b1011);
      check("t2_nbits",    rec_n, 4);
      check("t2_ndone",    n_done, 1);

      // stall of three cycles after the second bit
      clear_rec();
      ld = 1'b1; d = 4'b0110;
      tick();
      ld = 1'b0;
      tick();
      en = 1'b0;
      repeat (3) tick();
      en = 1'b1;
      repeat (6) tick();
      check("t4_bits",  rec_l, 32'b0111110);
      check("t4_nbits", rec_n, 7);
      check("t4_ndone", n_done, 1);

      // load ignored while busy, accepted in the done cycle
      clear_rec();
      ld = 1'b1; d = 4'h5;
      tick();
      d = 4'hA;
      repeat (3) tick();
      ld = 1'b0;
      tick();
      check("t5_done_cycle", done_l, 1'b1);
      ld = 1'b1; d = 4'hC;
      tick();
      ld = 1'b0;
      repeat (6) tick();
      check("t5_bits",  rec_l, 32'b10100011);
      check("t5_nbits", rec_n, 8);
      check("t5_ndone", n_done, 2);

      // reset mid-word aborts it, then a fresh word goes out
      clear_rec();
      ld = 1'b1; d = 4'h9;
      tick();
      ld = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      check("t6_abort_valid", so_valid_l, 1'b0);
      check("t6_abort_done",  done_l,     1'b0);
      reset = 1'b0;
      ld = 1'b1; d = 4'h3;
      tick();
      ld = 1'b0;
      repeat (6) tick();
      check("t6_bits",  rec_l, 32'b101100);
      check("t6_nbits", rec_n, 6);
      check("t6_ndone", n_done, 1);

      chk_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
